// File: rtl/uart_cmd_decoder_pkg.sv
// Shared definitions for the UART command decoder: command byte codes,
// FSM state encoding and the byte-to-command decode helper.
package uart_cmd_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_ECHO   = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    localparam logic [7:0] CMD_RUN_UC   = 8'h52;
    localparam logic [7:0] CMD_RUN_LC   = 8'h72;
    localparam logic [7:0] CMD_CLR_UC   = 8'h43;
    localparam logic [7:0] CMD_CLR_LC   = 8'h63;
    localparam logic [7:0] CMD_HOUR_UC  = 8'h48;
    localparam logic [7:0] CMD_HOUR_LC  = 8'h68;
    localparam logic [7:0] CMD_MIN_UC   = 8'h4D;
    localparam logic [7:0] CMD_MIN_LC   = 8'h6D;
    localparam logic [7:0] CMD_SEC_UC   = 8'h53;
    localparam logic [7:0] CMD_SEC_LC   = 8'h73;
    localparam logic [7:0] ECHO_INVALID = 8'h3F;

    typedef struct packed {
        logic run;
        logic clear;
        logic hour;
        logic min;
        logic sec;
    } pulse_t;

    typedef struct packed {
        pulse_t     pulses;
        logic [7:0] echo;
    } cmd_t;

    // Case-insensitive match; the echo is always the uppercase letter or '?'.
    function automatic cmd_t decode_cmd(input logic [7:0] b);
        cmd_t c;
        c.pulses = pulse_t'(5'b00000);
        c.echo   = ECHO_INVALID;
        case (b)
            CMD_RUN_UC, CMD_RUN_LC: begin
                c.pulses.run = 1'b1;
                c.echo       = CMD_RUN_UC;
            end
            CMD_CLR_UC, CMD_CLR_LC: begin
                c.pulses.clear = 1'b1;
                c.echo         = CMD_CLR_UC;
            end
            CMD_HOUR_UC, CMD_HOUR_LC: begin
                c.pulses.hour = 1'b1;
                c.echo        = CMD_HOUR_UC;
            end
            CMD_MIN_UC, CMD_MIN_LC: begin
                c.pulses.min = 1'b1;
                c.echo       = CMD_MIN_UC;
            end
            CMD_SEC_UC, CMD_SEC_LC: begin
                c.pulses.sec = 1'b1;
                c.echo       = CMD_SEC_UC;
            end
            default: begin
                c.pulses = pulse_t'(5'b00000);
                c.echo   = ECHO_INVALID;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/uart_cmd_decoder_fifo.sv
// Receive-byte FIFO with extra-MSB pointers so full and empty are told apart
// without a separate occupancy counter.
module cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];

    // Pointer advance and storage write.
    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = (push && (wr_ptr_q[ADDR_W-1:0] == ADDR_W'(i))) ? din : mem_q[i];
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign dout  = mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

endmodule

// File: rtl/uart_cmd_decoder.sv
// Decodes single-letter commands from a UART byte stream into one-cycle
// stopwatch control pulses and optionally echoes each command back.
module uart_cmd_decoder
    import uart_cmd_decoder_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter int unsigned ECHO_EN    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       tx_busy,
    output logic       o_pc_run,
    output logic       o_pc_clear,
    output logic       o_pc_hour,
    output logic       o_pc_min,
    output logic       o_pc_sec,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       o_overflow
);

    state_e     state_q, state_d;
    logic [7:0] byte_q, byte_d;
    pulse_t     pulse_q, pulse_d;
    logic       tx_start_q, tx_start_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       overflow_q, overflow_d;

    logic       fifo_push_s;
    logic       fifo_pop_s;
    logic [7:0] fifo_dout_s;
    logic       fifo_full_s;
    logic       fifo_empty_s;
    cmd_t       cmd_s;

    cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .din   (rx_data),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign cmd_s = decode_cmd(byte_q);

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    always_comb begin
        fifo_push_s = rx_done && (!fifo_full_s || fifo_pop_s);
        overflow_d  = overflow_q || (rx_done && fifo_full_s && !fifo_pop_s);
    end

    // Next-state and registered-output logic of the command FSM.
    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        pulse_d    = pulse_t'(5'b00000);
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        fifo_pop_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    byte_d     = fifo_dout_s;
                    state_d    = ST_DECODE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DECODE: begin
                pulse_d = cmd_s.pulses;
                if (ECHO_EN != 32'd0) begin
                    state_d = ST_ECHO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ECHO: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = cmd_s.echo;
                    state_d    = ST_HOLD;
                end else begin
                    state_d = ST_ECHO;
                end
            end
            // One dead cycle lets uart_tx raise tx_busy before the next echo.
            ST_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            byte_q     <= 8'h00;
            pulse_q    <= pulse_t'(5'b00000);
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            pulse_q    <= pulse_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_pc_run   = pulse_q.run;
    assign o_pc_clear = pulse_q.clear;
    assign o_pc_hour  = pulse_q.hour;
    assign o_pc_min   = pulse_q.min;
    assign o_pc_sec   = pulse_q.sec;
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: expected pulses/echoes are queued at
// stimulus time and a negedge monitor pops and compares them.
module tb_uart_cmd_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_busy;
    logic       o_pc_run, o_pc_clear, o_pc_hour, o_pc_min, o_pc_sec;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       o_overflow;

    logic [7:0] rx_data0;
    logic       rx_done0;
    logic       tx_busy0;
    logic       run0, clear0, hour0, min0, sec0, tx_start0, ovf0;
    logic [7:0] tx_data0;

    always #5 clk = ~clk;

    uart_cmd_decoder #(.FIFO_DEPTH(4), .ECHO_EN(1)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
        .tx_busy(tx_busy), .o_pc_run(o_pc_run), .o_pc_clear(o_pc_clear),
        .o_pc_hour(o_pc_hour), .o_pc_min(o_pc_min), .o_pc_sec(o_pc_sec),
        .tx_start(tx_start), .tx_data(tx_data), .o_overflow(o_overflow)
    );

    uart_cmd_decoder #(.FIFO_DEPTH(4), .ECHO_EN(0)) dut0 (
        .clk(clk), .reset(reset), .rx_data(rx_data0), .rx_done(rx_done0),
        .tx_busy(tx_busy0), .o_pc_run(run0), .o_pc_clear(clear0),
        .o_pc_hour(hour0), .o_pc_min(min0), .o_pc_sec(sec0),
        .tx_start(tx_start0), .tx_data(tx_data0), .o_overflow(ovf0)
    );

    typedef struct { logic [4:0] pulse; int cyc; } exp_pulse_t;
    typedef struct { logic [7:0] data;  int cyc; } exp_echo_t;

    exp_pulse_t exp_pulse[$];
    exp_echo_t  exp_echo[$];

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int pulse_count = 0;
    int clr0_count = 0, other0_count = 0, start0_count = 0;
    bit busy_stuck = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: case-insensitive letter map, uppercase echo or '?'.
    function automatic logic [7:0] upcase(input logic [7:0] b);
        return (b >= "a" && b <= "z") ? (b - 8'h20) : b;
    endfunction

    function automatic logic [4:0] pulse_of(input logic [7:0] b);
        case (upcase(b))
            "R":     return 5'b10000;
            "C":     return 5'b01000;
            "H":     return 5'b00100;
            "M":     return 5'b00010;
            "S":     return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    task automatic expect_byte(input logic [7:0] b, input int pcyc, input int ecyc);
        exp_pulse_t p;
        exp_echo_t  e;
        if (pulse_of(b) != 5'b00000) begin
            p.pulse = pulse_of(b);
            p.cyc   = pcyc;
            exp_pulse.push_back(p);
        end
        e.data = (pulse_of(b) != 5'b00000) ? upcase(b) : 8'h3F;
        e.cyc  = ecyc;
        exp_echo.push_back(e);
    endtask

    // Called at posedge+1; returns the edge index at which the byte was sampled.
    task automatic send(input logic [7:0] b, output int n);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        n = cyc;
        rx_done = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((exp_pulse.size() + exp_echo.size()) != 0 && k < budget) begin
            tick(1);
            k++;
        end
        chk("drain", exp_pulse.size() + exp_echo.size(), 0);
    endtask

    // Simple uart_tx stand-in: busy from the cycle after tx_start for a random time.
    initial begin : busy_model
        int  cnt;
        logic seen;
        tx_busy = 1'b0;
        cnt = 0;
        forever begin
            @(negedge clk);
            seen = tx_start;
            @(posedge clk);
            #1;
            if (busy_stuck) begin
                tx_busy = 1'b1;
            end else if (seen) begin
                cnt = $urandom_range(1, 8);
                tx_busy = 1'b1;
            end else if (cnt > 0) begin
                cnt--;
                tx_busy = (cnt != 0);
            end else begin
                tx_busy = 1'b0;
            end
        end
    end

    // Monitor: compare every presented pulse / echo against the scoreboard.
    initial begin : monitor
        logic [4:0] pv, prev_pv;
        logic       prev_busy, prev_start;
        exp_pulse_t ep;
        exp_echo_t  ee;
        prev_pv = 5'b0; prev_busy = 1'b0; prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_pv = 5'b0; prev_busy = 1'b0; prev_start = 1'b0;
            end else begin
                pv = {o_pc_run, o_pc_clear, o_pc_hour, o_pc_min, o_pc_sec};
                if (pv != 5'b0) begin
                    pulse_count++;
                    chk("pulse_onehot", 32'($countones(pv)), 1);
                    chk("pulse_width", 32'(pv & prev_pv), 0);
                    if (exp_pulse.size() == 0) begin
                        chk("unexpected_pulse", 32'(pv), 0);
                    end else begin
                        ep = exp_pulse.pop_front();
                        chk("pulse", 32'(pv), 32'(ep.pulse));
                        if (ep.cyc >= 0) chk("pulse_latency", cyc, ep.cyc);
                    end
                end
                if (tx_start) begin
                    chk("tx_start_width", 32'(prev_start), 0);
                    chk("tx_start_busy_low", 32'(prev_busy), 0);
                    if (exp_echo.size() == 0) begin
                        chk("unexpected_tx_start", 32'(tx_start), 0);
                    end else begin
                        ee = exp_echo.pop_front();
                        chk("echo_data", 32'(tx_data), 32'(ee.data));
                        if (ee.cyc >= 0) chk("echo_latency", cyc, ee.cyc);
                    end
                end
                prev_pv = pv; prev_busy = tx_busy; prev_start = tx_start;
            end
        end
    end

    // Event counters for the no-echo instance.
    always @(negedge clk) begin
        if (!reset) begin
            if (clear0) clr0_count++;
            if (run0 || hour0 || min0 || sec0) other0_count++;
            if (tx_start0) start0_count++;
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n, pc0, nb;
        logic [7:0] b;
        logic [7:0] letters [10];
        logic [7:0] bytes6 [6];
        letters = '{"R", "r", "C", "c", "H", "h", "M", "m", "S", "s"};
        reset = 1'b1; rx_done = 1'b0; rx_data = 8'h00;
        rx_done0 = 1'b0; rx_data0 = 8'h00; tx_busy0 = 1'b0;
        tick(3);
        chk("reset_pulses", 32'({o_pc_run, o_pc_clear, o_pc_hour, o_pc_min, o_pc_sec}), 0);
        chk("reset_tx_start", 32'(tx_start), 0);
        chk("reset_tx_data", 32'(tx_data), 0);
        chk("reset_overflow", 32'(o_overflow), 0);
        reset = 1'b0;
        tick(3);

        // Single 'R' with idle transmitter: exact pulse and echo timing.
        send(8'h52, n);
        expect_byte(8'h52, n + 2, n + 3);
        wait_drain(50);
        tick(12);

        send(8'h73, n);
        expect_byte(8'h73, n + 2, n + 3);
        wait_drain(50);
        tick(12);
        send(8'h41, n);
        expect_byte(8'h41, -1, n + 3);
        wait_drain(50);
        tick(12);

        // Random short bursts; never deep enough to overflow.
        for (int i = 0; i < 30; i++) begin
            nb = $urandom_range(1, 4);
            for (int j = 0; j < nb; j++) begin
                b = ($urandom_range(0, 1) == 0) ? letters[$urandom_range(0, 9)] : 8'($urandom);
                send(b, n);
                expect_byte(b, -1, -1);
                tick($urandom_range(0, 2));
            end
            wait_drain(400);
            tick(10);
        end
        chk("no_overflow_random", 32'(o_overflow), 0);

        // Transmitter busy for 50 cycles while 'H','M','S' arrive back-to-back.
        busy_stuck = 1'b1;
        tick(2);
        pc0 = pulse_count;
        send("H", n); expect_byte("H", n + 2, -1);
        send("M", n); expect_byte("M", -1, -1);
        send("S", n); expect_byte("S", -1, -1);
        tick(47);
        chk("busy_single_pulse", pulse_count - pc0, 1);
        busy_stuck = 1'b0;
        wait_drain(200);
        tick(12);

        // Six bytes into a depth-4 FIFO with the transmitter stuck busy.
        busy_stuck = 1'b1;
        tick(2);
        pc0 = pulse_count;
        for (int j = 0; j < 6; j++) begin
            bytes6[j] = letters[$urandom_range(0, 9)];
            send(bytes6[j], n);
            if (j < 5) expect_byte(bytes6[j], -1, -1);
        end
        tick(3);
        chk("ovf_set", 32'(o_overflow), 1);
        chk("ovf_single_pulse", pulse_count - pc0, 1);
        tick(20);
        chk("ovf_sticky_busy", 32'(o_overflow), 1);
        busy_stuck = 1'b0;
        wait_drain(300);
        tick(12);
        chk("ovf_sticky_after", 32'(o_overflow), 1);

        // Reset in ECHO with two bytes queued: echo aborted, queue discarded.
        busy_stuck = 1'b1;
        tick(2);
        send("R", n); expect_byte("R", n + 2, -1);
        send("C", n);
        send("M", n);
        tick(2);
        chk("pre_reset_pulse_seen", exp_pulse.size(), 0);
        exp_echo.delete();
        pc0 = pulse_count;
        reset = 1'b1;
        busy_stuck = 1'b0;
        @(negedge clk);
        chk("rst_pulses", 32'({o_pc_run, o_pc_clear, o_pc_hour, o_pc_min, o_pc_sec}), 0);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_overflow", 32'(o_overflow), 0);
        tick(2);
        reset = 1'b0;
        tick(40);
        chk("post_reset_no_pulse", pulse_count - pc0, 0);

        // No-echo instance: 'C' every third cycle, twenty times.
        for (int j = 0; j < 20; j++) begin
            rx_data0 = "C";
            rx_done0 = 1'b1;
            tick(1);
            rx_done0 = 1'b0;
            tick(2);
        end
        tick(10);
        chk("noecho_clear_count", clr0_count, 20);
        chk("noecho_other_pulses", other0_count, 0);
        chk("noecho_tx_start", start0_count, 0);
        chk("noecho_overflow", 32'(ovf0), 0);

        chk("final_queues_empty", exp_pulse.size() + exp_echo.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
